// File: rtl/ascon_pack.sv
// Shared definitions for the ASCON permutation round sequencer.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_perm_ctrl_state;

  // Index of the final ASCON round; every permutation ends on this round.
  localparam logic [3:0] ROUND_LAST    = 4'd11;
  localparam int         NB_ROUNDS_MAX = 12;

  // First round index of a p^n call: the last n rounds of the 12-round schedule.
  function automatic logic [3:0] round_start(input int n);
    return 4'(NB_ROUNDS_MAX - n);
  endfunction

endpackage

// File: rtl/round_counter.sv
// 4-bit round index counter: synchronous clear, load and increment, with a
// flag marking the final ASCON round.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  logic [3:0] count_d;
  logic [3:0] count_q;

  // Next count: clear beats load, load beats increment.
  always_comb begin
    // NOTE: assigning the hold value first keeps every path covered, so no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetb_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == ROUND_LAST);

endmodule

// File: rtl/permutation_ctrl.sv
// Round sequencer for the ASCON permutation datapath: loads the external
// state, iterates p over the selected round indices and pulses done_o.
module permutation_ctrl
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       selectionp_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o
);

  if ((ROUNDS_A < 1) || (ROUNDS_A > NB_ROUNDS_MAX) ||
      (ROUNDS_B < 1) || (ROUNDS_B > NB_ROUNDS_MAX)) begin : g_bad_rounds
    $error("permutation_ctrl: ROUNDS_A and ROUNDS_B must lie in 1..%0d", NB_ROUNDS_MAX);
  end

  localparam logic [3:0] START_A = round_start(ROUNDS_A);
  localparam logic [3:0] START_B = round_start(ROUNDS_B);

  type_perm_ctrl_state state_d, state_q;
  logic                first_d, first_q;

  logic       cnt_clr;
  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_inc;
  logic [3:0] cnt_count;
  logic       cnt_last;

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .count_o    (cnt_count),
    .last_o     (cnt_last)
  );

  // Next state, counter controls and registered-state output decode.
  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = START_B;
    cnt_inc      = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
      first_d = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE accepts a start exactly like IDLE, so back-to-back calls have no bubble.
          if (start_i) begin
            state_d      = RUN;
            first_d      = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = mode_i ? START_A : START_B;
          end else begin
            state_d = IDLE;
            first_d = 1'b0;
            cnt_clr = 1'b1;
          end
        end
        RUN: begin
          first_d = 1'b0;
          if (cnt_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          first_d = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end

    // Outputs depend only on registered state, so there is no input-to-output path.
    selectionp_o = (state_q == RUN) && !first_q;
    enable_o     = (state_q == RUN);
    busy_o       = (state_q == RUN);
    ready_o      = (state_q != RUN);
    done_o       = (state_q == DONE);
    round_o      = (state_q == RUN) ? cnt_count : 4'd0;
  end

  // State and first-round flag registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: the driver pushes the expected
// round/done sequence for each accepted start, the monitor pops and compares.
module tb_permutation_ctrl;

  localparam int RA = 12;
  localparam int RB = 6;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i, mode_i, abort_i;
  logic       selectionp_o, enable_o, ready_o, busy_o, done_o;
  logic [3:0] round_o;

  // Second instance with single-round p^a and full 12-round p^b.
  logic       start1, mode1, abort1;
  logic       sel1, en1, ready1, busy1, done1;
  logic [3:0] round1;

  typedef struct packed {
    logic       is_done;
    logic [3:0] round;
    logic       sel;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clock_i = ~clock_i;

  permutation_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) u_dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .abort_i      (abort_i),
    .selectionp_o (selectionp_o),
    .enable_o     (enable_o),
    .round_o      (round_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  permutation_ctrl #(.ROUNDS_A(1), .ROUNDS_B(12)) u_dut1 (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start1),
    .mode_i       (mode1),
    .abort_i      (abort1),
    .selectionp_o (sel1),
    .enable_o     (en1),
    .round_o      (round1),
    .ready_o      (ready1),
    .busy_o       (busy1),
    .done_o       (done1)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: p^n applies the last n of the 12 rounds, loads external state
  // on its first round only, then reports completion once.
  task automatic push_run(input logic m);
    int  n;
    int  first;
    ev_t ev;
    n     = m ? RA : RB;
    first = 12 - n;
    for (int r = first; r < 12; r++) begin
      ev.is_done = 1'b0;
      ev.round   = 4'(r);
      ev.sel     = (r != first);
      exp_q.push_back(ev);
    end
    ev.is_done = 1'b1;
    ev.round   = 4'd0;
    ev.sel     = 1'b0;
    exp_q.push_back(ev);
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    repeat (n) step();
  endtask

  // Issue a start, toggle start/mode noise while running, return in the done cycle.
  task automatic do_run(input logic m);
    int n;
    n       = m ? RA : RB;
    start_i = 1'b1;
    mode_i  = m;
    step();
    push_run(m);
    for (int i = 0; i < n; i++) begin
      start_i = 1'($urandom_range(0, 1));
      mode_i  = 1'($urandom);
      step();
    end
    start_i = 1'b0;
  endtask

  // Monitor: every cycle either pops an expected event or confirms idle outputs.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock_i);
      if (enable_o || done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: enable=%0b done=%0b round=%0d with nothing expected at %0t",
                   enable_o, done_o, round_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("done", 4'(done_o), 4'(e.is_done));
          check("enable", 4'(enable_o), 4'(!e.is_done));
          check("busy", 4'(busy_o), 4'(!e.is_done));
          check("ready", 4'(ready_o), 4'(e.is_done));
          check("round", round_o, e.is_done ? 4'd0 : e.round);
          check("selectionp", 4'(selectionp_o), 4'(e.sel));
        end
      end else begin
        check("idle_ready", 4'(ready_o), 4'd1);
        check("idle_busy", 4'(busy_o), 4'd0);
        check("idle_round", round_o, 4'd0);
        check("idle_sel", 4'(selectionp_o), 4'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    resetb_i = 1'b0;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    abort_i  = 1'b0;
    start1   = 1'b0;
    mode1    = 1'b0;
    abort1   = 1'b0;
    repeat (3) step();
    check("rst_ready", 4'(ready_o), 4'd1);
    check("rst_busy", 4'(busy_o), 4'd0);
    check("rst_enable", 4'(enable_o), 4'd0);
    check("rst_round", round_o, 4'd0);
    check("rst_done", 4'(done_o), 4'd0);
    resetb_i = 1'b1;
    idle(3);

    // Directed p^12, p^6, then back-to-back with toggled mode.
    do_run(1'b1);
    idle(2);
    do_run(1'b0);
    idle(2);
    do_run(1'b1);
    do_run(1'b0);
    do_run(1'b1);
    idle(2);

    // Abort during round 3 of p^12.
    start_i = 1'b1;
    mode_i  = 1'b1;
    step();
    push_run(1'b1);
    start_i = 1'b0;
    repeat (3) step();
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    exp_q.delete();
    check("abort_ready", 4'(ready_o), 4'd1);
    check("abort_busy", 4'(busy_o), 4'd0);
    check("abort_done", 4'(done_o), 4'd0);
    idle(2);

    // Abort together with start in IDLE stays IDLE.
    abort_i = 1'b1;
    start_i = 1'b1;
    mode_i  = 1'($urandom);
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_start_busy", 4'(busy_o), 4'd0);
    check("abort_start_enable", 4'(enable_o), 4'd0);
    check("abort_start_ready", 4'(ready_o), 4'd1);
    idle(2);

    // Asynchronous reset while round 8 is applied.
    start_i = 1'b1;
    mode_i  = 1'b1;
    step();
    push_run(1'b1);
    start_i = 1'b0;
    repeat (8) step();
    #1;
    resetb_i = 1'b0;
    exp_q.delete();
    #1;
    check("arst_ready", 4'(ready_o), 4'd1);
    check("arst_busy", 4'(busy_o), 4'd0);
    check("arst_enable", 4'(enable_o), 4'd0);
    check("arst_round", round_o, 4'd0);
    check("arst_sel", 4'(selectionp_o), 4'd0);
    check("arst_done", 4'(done_o), 4'd0);
    step();
    resetb_i = 1'b1;
    idle(1);
    do_run(1'b0);
    idle(2);

    // Randomized mix of modes with and without back-to-back starts.
    repeat (20) begin
      m = 1'($urandom);
      do_run(m);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Single-round p^a: one RUN cycle loading external state at round 11.
    start1 = 1'b1;
    mode1  = 1'b1;
    step();
    start1 = 1'b0;
    check("n1_enable", 4'(en1), 4'd1);
    check("n1_sel", 4'(sel1), 4'd0);
    check("n1_round", round1, 4'd11);
    check("n1_ready", 4'(ready1), 4'd0);
    step();
    check("n1_done", 4'(done1), 4'd1);
    check("n1_done_enable", 4'(en1), 4'd0);
    step();
    check("n1_done_pulse", 4'(done1), 4'd0);

    // Twelve-round p^b on the same instance: rounds 0..11.
    start1 = 1'b1;
    mode1  = 1'b0;
    step();
    start1 = 1'b0;
    for (int r = 0; r < 12; r++) begin
      check("n12_round", round1, 4'(r));
      check("n12_sel", 4'(sel1), 4'(r != 0));
      step();
    end
    check("n12_done", 4'(done1), 4'd1);
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
